eth_rx_buf_ctrl: RTL and testbench
==================================

Name: eth_rx_buf_ctrl

Overview:
- Receive frame-buffer controller placed after the RMII receive path.
- Takes the byte stream and frame delimiters from the receive datapath and writes the bytes speculatively into an internal circular byte buffer.
- At frame end, commits the frame if the CRC check passed and there was no overflow; otherwise rewinds the write pointer to discard it.
- Committed frames are replayed to downstream logic over a valid/ready byte stream with a last marker.

Parameters:
- pADDR_WIDTH, 11, buffer depth = 2^pADDR_WIDTH entries; each entry is 9 bits (byte + last flag).
- pCNT_WIDTH, 16, width of the good-frame and dropped-frame counters.

Ports:
- Clk  in  1  system clock (50 MHz RMII reference)
- Rst  in  1  synchronous, active-high reset
- Frame_Start  in  1  one-cycle pulse; a new frame's first byte follows
- Byte_Rdy  in  1  one-cycle strobe; Byte is valid
- Byte  in  8  received byte
- Frame_End  in  1  one-cycle pulse after the last Byte_Rdy of the frame
- Crc_Valid  in  1  CRC check result; sampled only in the Frame_End cycle
- M_Tdata  out  8  output byte
- M_Tvalid  out  1  output byte valid
- M_Tlast  out  1  marks the last byte of a frame
- M_Tready  in  1  downstream accepts the byte
- Frame_Good_Cnt  out  pCNT_WIDTH  count of committed frames, saturating
- Frame_Drop_Cnt  out  pCNT_WIDTH  count of discarded frames, saturating
- Overflow  out  1  one-cycle pulse when a frame is dropped because the buffer was full

Behaviour:
- Reset: all outputs 0; the wr, commit and rd pointers are 0; state IDLE; the pending-byte register is empty.
- Pointers are pADDR_WIDTH+1 bits wide.
  - full = (wr[MSB] != rd[MSB]) & (wr[low] == rd[low])
  - empty (read side) = (rd == commit)
- States: IDLE, RECV, DROP.
- IDLE:
  - Frame_Start -> RECV; wr is reloaded from commit; pending is cleared.
  - Byte_Rdy and Frame_End are ignored.
- RECV, on Byte_Rdy:
  - If pending is valid, write the pending byte with last=0 and increment wr.
  - Load the new Byte into pending.
  - If full at the moment a write is needed -> DROP; Overflow pulses the next cycle.
- RECV, on Frame_End:
  - If pending is valid, write it with last=1.
  - If Crc_Valid=1: commit <= wr+1 (this includes the last write) and Frame_Good_Cnt++.
  - Else: wr <= commit and Frame_Drop_Cnt++.
  - Next state IDLE.
  - Frame_End with no bytes received: counts as a drop; no write.
- DROP:
  - Byte_Rdy is ignored.
  - On Frame_End: wr <= commit, Frame_Drop_Cnt++, -> IDLE.
- Frame_Start while in RECV or DROP: the current frame is discarded (wr <= commit, Frame_Drop_Cnt++) and RECV restarts for the new frame in the same cycle.
- Frame_End and Frame_Start in the same cycle: the end is processed first, then the start; the next state is RECV.
- The commit pointer only moves on a successful Frame_End. The read side never sees bytes from an uncommitted frame.
- Read side:
  - Buffer memory with a registered read; the output register works as a one-entry skid (FWFT).
  - M_Tvalid rises within 3 cycles of the commit pointer passing rd.
  - M_Tdata and M_Tlast stay stable while M_Tvalid & !M_Tready.
  - Each handshake (M_Tvalid & M_Tready) advances one byte.
  - Back-to-back bytes are supported at 1 byte/cycle with M_Tready held high.
- Write and read in the same cycle are allowed. full is evaluated against rd before that cycle's read.
- Counters saturate at all-ones; they do not wrap.
- Rst asserted mid-frame or mid-readout: all pointers are cleared and the buffered frames are lost. The counters are cleared.

Optional Feature:
- Macro: ETH_RX_MIN_LEN_EN
- Defined:
  - A byte counter (11 bits, saturating) counts the bytes in RECV.
  - At Frame_End, a frame with fewer than 64 bytes (including the FCS) is discarded even when Crc_Valid=1; Frame_Drop_Cnt++.
- Undefined: no length check; any frame with at least 1 byte and a good CRC is committed.

Test Plan:
- 64-byte frame 0x00..0x3F with Crc_Valid=1 at Frame_End, M_Tready=1 -> 64 bytes out in order, M_Tlast on 0x3F, Frame_Good_Cnt=1.
- Same frame with Crc_Valid=0 -> M_Tvalid never asserts; Frame_Drop_Cnt=1; a following good frame comes out with its own first byte (rewind verified).
- pADDR_WIDTH=6, M_Tready=0, 100-byte frame -> Overflow pulse, Frame_Drop_Cnt=1, no output. A later 40-byte good frame with M_Tready=1 is delivered intact.
- Two good frames back-to-back while M_Tready toggles 1,0,1,0 -> data is stable while stalled; exactly two M_Tlast pulses, one per frame.
- Frame_Start mid-frame after 10 bytes, then a 64-byte good frame -> the first frame is dropped (Frame_Drop_Cnt=1) and only the 64 bytes are output.
- With ETH_RX_MIN_LEN_EN defined: a 63-byte frame with Crc_Valid=1 is dropped and a 64-byte frame is committed. Without the macro, both are committed.

Source files
------------

// File: rtl/eth_rx_buf_ctrl_if.sv
// Byte-stream interfaces of the receive frame buffer: the delimited byte stream from the
// receive datapath, and the valid/ready replay stream to downstream logic.
interface eth_rx_byte_if;
  logic       Frame_Start;
  logic       Byte_Rdy;
  logic [7:0] Byte;
  logic       Frame_End;
  logic       Crc_Valid;

  modport master (output Frame_Start, Byte_Rdy, Byte, Frame_End, Crc_Valid);
  modport slave  (input  Frame_Start, Byte_Rdy, Byte, Frame_End, Crc_Valid);
endinterface

interface eth_rx_stream_if;
  logic [7:0] M_Tdata;
  logic       M_Tvalid;
  logic       M_Tlast;
  logic       M_Tready;

  modport master (output M_Tdata, M_Tvalid, M_Tlast, input  M_Tready);
  modport slave  (input  M_Tdata, M_Tvalid, M_Tlast, output M_Tready);
endinterface

// File: rtl/eth_rx_buf_ctrl.sv
// Receive frame buffer: speculative writes into a circular byte buffer, commit/rewind at
// frame end, FWFT replay of committed frames. ETH_RX_MIN_LEN_EN adds a 64-byte minimum length.
module eth_rx_buf_ctrl #(
  parameter int pADDR_WIDTH = 11,
  parameter int pCNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  eth_rx_byte_if.slave          rx,
  eth_rx_stream_if.master       mAxis,
  output logic [pCNT_WIDTH-1:0] Frame_Good_Cnt,
  output logic [pCNT_WIDTH-1:0] Frame_Drop_Cnt,
  output logic                  Overflow
);

  localparam int PW    = pADDR_WIDTH + 1;
  localparam int DEPTH = 1 << pADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t          state;
  logic [PW-1:0]   wrPtr, commitPtr, rdPtr;
  logic            pendValid;
  logic [7:0]      pendByte;
  logic [8:0]      mem [DEPTH];

  logic            full, lenOk, commitOk, memWe;
  logic [8:0]      memWdata;

  logic            s1Vld, outVld, outLast;
  logic [8:0]      s1Data;
  logic [7:0]      outData;
  logic            pop, s1Move, rdEn;

  function automatic logic [pCNT_WIDTH-1:0] satInc(input logic [pCNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign full = (wrPtr[PW-1] != rdPtr[PW-1]) &&
                (wrPtr[pADDR_WIDTH-1:0] == rdPtr[pADDR_WIDTH-1:0]);

  // The pending byte is written once we know whether it is the frame's last byte.
  assign memWe    = (state == RECV) && pendValid && !full &&
                    (rx.Frame_End || (rx.Byte_Rdy && !rx.Frame_Start));
  assign memWdata = {rx.Frame_End, pendByte};
  assign commitOk = rx.Crc_Valid && pendValid && !full && lenOk;

`ifdef ETH_RX_MIN_LEN_EN
  logic [10:0] byteCnt;

  always_ff @(posedge Clk) begin
    if (Rst)
      byteCnt <= '0;
    else if (rx.Frame_Start)
      byteCnt <= '0;
    else if (state == RECV && rx.Byte_Rdy && !rx.Frame_End && !(&byteCnt))
      byteCnt <= byteCnt + 1'b1;
  end

  assign lenOk = (byteCnt >= 11'd64);
`else
  assign lenOk = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= IDLE;
      wrPtr          <= '0;
      commitPtr      <= '0;
      pendValid      <= 1'b0;
      pendByte       <= '0;
      Frame_Good_Cnt <= '0;
      Frame_Drop_Cnt <= '0;
      Overflow       <= 1'b0;
    end else begin
      Overflow <= 1'b0;
      case (state)
        IDLE: begin
          if (rx.Frame_Start) begin
            state     <= RECV;
            wrPtr     <= commitPtr;
            pendValid <= 1'b0;
          end
        end
        RECV: begin
          if (rx.Frame_End) begin
            // End first; a coincident start reopens RECV at the (possibly new) commit point.
            pendValid <= 1'b0;
            state     <= rx.Frame_Start ? RECV : IDLE;
            if (commitOk) begin
              commitPtr      <= wrPtr + 1'b1;
              wrPtr          <= wrPtr + 1'b1;
              Frame_Good_Cnt <= satInc(Frame_Good_Cnt);
            end else begin
              wrPtr          <= commitPtr;
              Frame_Drop_Cnt <= satInc(Frame_Drop_Cnt);
              Overflow       <= pendValid && full;
            end
          end else if (rx.Frame_Start) begin
            wrPtr          <= commitPtr;
            pendValid      <= 1'b0;
            Frame_Drop_Cnt <= satInc(Frame_Drop_Cnt);
          end else if (rx.Byte_Rdy) begin
            if (pendValid && full) begin
              state     <= DROP;
              pendValid <= 1'b0;
              Overflow  <= 1'b1;
            end else begin
              if (pendValid) wrPtr <= wrPtr + 1'b1;
              pendValid <= 1'b1;
              pendByte  <= rx.Byte;
            end
          end
        end
        DROP: begin
          if (rx.Frame_End || rx.Frame_Start) begin
            wrPtr          <= commitPtr;
            pendValid      <= 1'b0;
            Frame_Drop_Cnt <= satInc(Frame_Drop_Cnt);
            state          <= rx.Frame_Start ? RECV : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read side: s1 holds the registered memory read, out is the skid/output register.
  assign pop    = outVld && mAxis.M_Tready;
  assign s1Move = s1Vld && (!outVld || pop);
  assign rdEn   = (rdPtr != commitPtr) && (!s1Vld || s1Move);

  always_ff @(posedge Clk) begin
    if (memWe) mem[wrPtr[pADDR_WIDTH-1:0]] <= memWdata;
    if (rdEn)  s1Data <= mem[rdPtr[pADDR_WIDTH-1:0]];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rdPtr   <= '0;
      s1Vld   <= 1'b0;
      outVld  <= 1'b0;
      outData <= '0;
      outLast <= 1'b0;
    end else begin
      if (rdEn) rdPtr <= rdPtr + 1'b1;
      s1Vld <= rdEn || (s1Vld && !s1Move);
      if (s1Move) begin
        outVld  <= 1'b1;
        outData <= s1Data[7:0];
        outLast <= s1Data[8];
      end else if (pop) begin
        outVld <= 1'b0;
      end
    end
  end

  assign mAxis.M_Tdata  = outData;
  assign mAxis.M_Tvalid = outVld;
  assign mAxis.M_Tlast  = outLast;

endmodule

// File: tb/tb_eth_rx_buf_ctrl.sv
// Bench for eth_rx_buf_ctrl: vector table, corner sequences and random frames checked
// against a frame-level model (committed frames appended to an expected byte queue).
module tb_eth_rx_buf_ctrl;

`ifdef ETH_RX_MIN_LEN_EN
  localparam bit MINLEN = 1'b1;
`else
  localparam bit MINLEN = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef logic [8:0] q9_t[$];
  typedef struct { int len; bit crc; int base; int dGood; int dDrop; } vec_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #10 Clk = ~Clk;

  eth_rx_byte_if   rxIf ();
  eth_rx_stream_if axA ();
  eth_rx_stream_if axB ();

  logic [15:0] goodA, dropA, goodB, dropB;
  logic        ovA, ovB;

  eth_rx_buf_ctrl dutA (
    .Clk(Clk), .Rst(Rst), .rx(rxIf), .mAxis(axA),
    .Frame_Good_Cnt(goodA), .Frame_Drop_Cnt(dropA), .Overflow(ovA));

  eth_rx_buf_ctrl #(.pADDR_WIDTH(6)) dutB (
    .Clk(Clk), .Rst(Rst), .rx(rxIf), .mAxis(axB),
    .Frame_Good_Cnt(goodB), .Frame_Drop_Cnt(dropB), .Overflow(ovB));

  int   total = 0, bad = 0;
  int   readyModeA = 0;   // 0 always ready, 1 never, 2 toggle, 3 random
  bit   readyB = 1'b0;
  int   ovCntB = 0;
  int   expGood = 0, expDrop = 0;
  q9_t  recvA, expA, recvB, expB;
  bit   stallA = 1'b0;
  logic [8:0] holdA;
  vec_t tbl[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Output monitor: ready pattern, handshake capture, hold-while-stalled check.
  initial begin
    axA.M_Tready = 1'b1;
    axB.M_Tready = 1'b0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        stallA = 1'b0;
      end else begin
        if (stallA)
          chk("stall_hold", {axA.M_Tvalid, axA.M_Tlast, axA.M_Tdata}, {1'b1, holdA});
        case (readyModeA)
          0:       axA.M_Tready = 1'b1;
          1:       axA.M_Tready = 1'b0;
          2:       axA.M_Tready = ~axA.M_Tready;
          default: axA.M_Tready = 1'($urandom_range(0, 1));
        endcase
        if (axA.M_Tvalid && axA.M_Tready) recvA.push_back({axA.M_Tlast, axA.M_Tdata});
        stallA = axA.M_Tvalid && !axA.M_Tready;
        holdA  = {axA.M_Tlast, axA.M_Tdata};
        axB.M_Tready = readyB;
        if (axB.M_Tvalid && axB.M_Tready) recvB.push_back({axB.M_Tlast, axB.M_Tdata});
        if (ovB) ovCntB++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic rx_cycle(input bit s, input bit r, input bit e, input bit c, input logic [7:0] b);
    @(posedge Clk); #2;
    rxIf.Frame_Start = s; rxIf.Byte_Rdy = r; rxIf.Frame_End = e;
    rxIf.Crc_Valid = c;   rxIf.Byte = b;
  endtask

  task automatic idle(); rx_cycle(0, 0, 0, 0, 8'h00); endtask

  function automatic bq_t ramp(input int n, input int base);
    bq_t d;
    for (int i = 0; i < n; i++) d.push_back(8'(base + i));
    return d;
  endfunction

  function automatic bit will_commit(input int len, input bit crc);
    return crc && (len >= (MINLEN ? 64 : 1));
  endfunction

  task automatic model_frame(input bq_t d, input bit crc);
    if (will_commit(d.size(), crc)) begin
      foreach (d[i]) expA.push_back({i == d.size() - 1, d[i]});
      expGood++;
    end else begin
      expDrop++;
    end
  endtask

  task automatic send_bytes(input bq_t d, input int maxGap);
    foreach (d[i]) begin
      rx_cycle(0, 1, 0, 0, d[i]);
      repeat ($urandom_range(0, maxGap)) idle();
    end
  endtask

  task automatic frame(input bq_t d, input bit crc, input int maxGap);
    rx_cycle(1, 0, 0, 0, 8'h00);
    send_bytes(d, maxGap);
    rx_cycle(0, 0, 1, crc, 8'h00);
    idle();
    model_frame(d, crc);
  endtask

  task automatic do_reset();
    @(posedge Clk); #2;
    Rst = 1'b1;
    rxIf.Frame_Start = 0; rxIf.Byte_Rdy = 0; rxIf.Frame_End = 0; rxIf.Crc_Valid = 0;
    repeat (3) @(posedge Clk);
    #2;
    Rst = 1'b0;
    recvA.delete(); expA.delete(); recvB.delete(); expB.delete();
    expGood = 0; expDrop = 0; ovCntB = 0;
  endtask

  task automatic drain_a(input string nm);
    int n = 0;
    while (recvA.size() < expA.size() && n < 6000) begin @(negedge Clk); n++; end
    repeat (8) @(negedge Clk);
    chk(nm, recvA.size(), expA.size());
  endtask

  task automatic cmp_q(input string nm, input q9_t got, input q9_t exp);
    int idx = -1;
    int gv = -1, ev = -1;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (idx < 0 && got[i] != exp[i]) idx = i;
    if (idx < 0 && got.size() != exp.size())
      idx = (got.size() < exp.size()) ? got.size() : exp.size();
    total++;
    if (idx >= 0) begin
      bad++;
      if (idx < got.size()) gv = int'(got[idx]);
      if (idx < exp.size()) ev = int'(exp[idx]);
      $display("FAIL %s: byte %0d got {last,data}=%0h want %0h (got %0d bytes, want %0d)",
               nm, idx, gv, ev, got.size(), exp.size());
    end
  endtask

  task automatic chk_cnts(input string nm);
    chk({nm, "_good"}, goodA, expGood);
    chk({nm, "_drop"}, dropA, expDrop);
  endtask

  initial begin
    int g0, d0, s0, lasts, sent, n;
    bq_t d;
    rxIf.Frame_Start = 0; rxIf.Byte_Rdy = 0; rxIf.Frame_End = 0; rxIf.Crc_Valid = 0;
    rxIf.Byte = 8'h00;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_tvalid", axA.M_Tvalid, 0);
    chk("rst_tdata",  axA.M_Tdata, 0);
    chk("rst_tlast",  axA.M_Tlast, 0);
    chk("rst_good",   goodA, 0);
    chk("rst_drop",   dropA, 0);
    chk("rst_ovf",    ovA, 0);
    do_reset();

    // Vector table
    tbl[0] = '{64, 1'b1, 'h00, 1, 0};
    tbl[1] = '{64, 1'b0, 'h00, 0, 1};
    tbl[2] = '{70, 1'b1, 'h80, 1, 0};
    tbl[3] = '{0,  1'b1, 'h00, 0, 1};
    tbl[4] = '{1,  1'b1, 'h55, MINLEN ? 0 : 1, MINLEN ? 1 : 0};
    tbl[5] = '{63, 1'b1, 'h10, MINLEN ? 0 : 1, MINLEN ? 1 : 0};
    tbl[6] = '{64, 1'b1, 'h20, 1, 0};
    readyModeA = 0;
    foreach (tbl[i]) begin
      g0 = int'(goodA); d0 = int'(dropA);
      frame(ramp(tbl[i].len, tbl[i].base), tbl[i].crc, (i == 0) ? 0 : 3);
      repeat (2) @(negedge Clk);
      chk($sformatf("vec%0d_good", i), int'(goodA) - g0, tbl[i].dGood);
      chk($sformatf("vec%0d_drop", i), int'(dropA) - d0, tbl[i].dDrop);
      drain_a($sformatf("vec%0d_bytes", i));
    end
    cmp_q("vec_stream", recvA, expA);

    // Frame_Start mid-frame aborts the current frame
    do_reset();
    rx_cycle(1, 0, 0, 0, 8'h00);
    send_bytes(ramp(10, 'hE0), 0);
    expDrop++;
    frame(ramp(64, 'h40), 1'b1, 1);
    drain_a("abort_bytes");
    cmp_q("abort_stream", recvA, expA);
    chk_cnts("abort");

    // Frame_End and Frame_Start in the same cycle
    do_reset();
    rx_cycle(1, 0, 0, 0, 8'h00);
    send_bytes(ramp(30, 'hA0), 0);
    rx_cycle(1, 0, 1, 1, 8'h00);
    send_bytes(ramp(66, 'h10), 1);
    rx_cycle(0, 0, 1, 1, 8'h00);
    idle();
    model_frame(ramp(30, 'hA0), 1'b1);
    model_frame(ramp(66, 'h10), 1'b1);
    drain_a("endstart_bytes");
    cmp_q("endstart_stream", recvA, expA);
    chk_cnts("endstart");

    // Two good frames while ready toggles
    do_reset();
    readyModeA = 2;
    frame(ramp(64, 'h00), 1'b1, 0);
    frame(ramp(70, 'h90), 1'b1, 0);
    drain_a("toggle_bytes");
    lasts = 0;
    foreach (recvA[i]) if (recvA[i][8]) lasts++;
    chk("toggle_lasts", lasts, 2);
    cmp_q("toggle_stream", recvA, expA);

    // Random frames, random backpressure, occasional aborts
    do_reset();
    readyModeA = 3;
    sent = 0;
    while (sent < 1700) begin
      if ($urandom_range(0, 7) == 0) begin
        n = $urandom_range(0, 20);
        d.delete();
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        rx_cycle(1, 0, 0, 0, 8'h00);
        send_bytes(d, 2);
        expDrop++;
        sent += n;
      end
      n = $urandom_range(0, 90);
      d.delete();
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      frame(d, $urandom_range(0, 3) != 0, 3);
      sent += n;
    end
    drain_a("rand_bytes");
    cmp_q("rand_stream", recvA, expA);
    chk_cnts("rand");

    // Reset mid-frame with a committed frame stuck behind backpressure
    readyModeA = 1;
    frame(ramp(64, 'h33), 1'b1, 0);
    rx_cycle(1, 0, 0, 0, 8'h00);
    send_bytes(ramp(30, 'h00), 0);
    do_reset();
    @(negedge Clk);
    chk("midrst_tvalid", axA.M_Tvalid, 0);
    chk("midrst_good", goodA, 0);
    chk("midrst_drop", dropA, 0);
    readyModeA = 0;
    frame(ramp(64, 'h70), 1'b1, 1);
    drain_a("midrst_bytes");
    cmp_q("midrst_stream", recvA, expA);

    // Small buffer overflow, then a good frame once drained
    do_reset();
    readyB = 1'b0;
    frame(ramp(100, 'h00), 1'b1, 0);
    repeat (4) @(negedge Clk);
    chk("ovf_pulses", ovCntB, 1);
    chk("ovf_drop", dropB, 1);
    chk("ovf_good", goodB, 0);
    chk("ovf_no_output", recvB.size() + int'(axB.M_Tvalid), 0);
    readyB = 1'b1;
    frame(ramp(40, 'hC0), 1'b1, 1);
    if (will_commit(40, 1'b1)) begin
      d = ramp(40, 'hC0);
      foreach (d[i]) expB.push_back({i == 39, d[i]});
    end
    n = 0;
    while (recvB.size() < expB.size() && n < 2000) begin @(negedge Clk); n++; end
    repeat (8) @(negedge Clk);
    cmp_q("ovf_after_stream", recvB, expB);
    chk("ovf_after_good", goodB, will_commit(40, 1'b1) ? 1 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
